// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mem_arb_pkg                                               |
// | Purpose : Shared types and RISC-V load/store funct3 encodings for   |
// |           the data-RAM arbiter.                                     |
// | Ports   : none (package)                                            |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : load_extend                                               |
// | Purpose : Combinational load-data extraction with sign/zero         |
// |           extension, plus funct3 legality and alignment checking.   |
// | Ports   : we_i       - access is a store (restricts legal funct3)   |
// |           funct3_i   - RISC-V load/store funct3                      |
// |           addr_lo_i  - byte offset within the word                  |
// |           word_i     - RAM read word                                |
// |           data_o     - extended load data (0 for stores/errors)     |
// |           err_o      - illegal funct3 or misaligned access          |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module load_extend
   import mem_arb_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o,
   output logic        err_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (addr_lo_i)
         2'd0:    w_byte = word_i[7:0];
         2'd1:    w_byte = word_i[15:8];
         2'd2:    w_byte = word_i[23:16];
         default: w_byte = word_i[31:24];
      endcase
      w_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = 32'h0;
      err_o  = 1'b0;
      case (funct3_i)
         F3_B:  data_o = {{24{w_byte[7]}}, w_byte};
         F3_H: begin
            err_o  = addr_lo_i[0];
            data_o = {{16{w_half[15]}}, w_half};
         end
         F3_W: begin
            err_o  = |addr_lo_i;
            data_o = word_i;
         end
         // Unsigned variants exist only for loads
         F3_BU: begin
            err_o  = we_i;
            data_o = {24'h0, w_byte};
         end
         F3_HU: begin
            err_o  = we_i | addr_lo_i[0];
            data_o = {16'h0, w_half};
         end
         default: err_o = 1'b1;
      endcase
      if (err_o || we_i) begin
         data_o = 32'h0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mem_arbiter                                               |
// | Purpose : Round-robin two-port arbiter/sequencer in front of the    |
// |           shared data RAM. One transaction per 3 cycles:            |
// |           IDLE (grant) -> ACCESS (RAM cycle) -> RESP (rvalid).      |
// | Ports   : clk, reset           - clock, sync active-high reset      |
// |           mN_req/we/funct3/addr/wdata - port N request fields       |
// |           mN_gnt               - combinational accept pulse         |
// |           mN_rvalid/rdata/err  - one-cycle response                 |
// |           ram_we/funct3/addr/wdata, ram_rdata - RAM interface       |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int AW          = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [2:0]    m0_funct3,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [2:0]    m1_funct3,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic          m1_err,
   output logic          ram_we,
   output logic [2:0]    ram_funct3,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   localparam logic [AW-3:0] c_DEPTH = (AW-2)'(DEPTH_WORDS);

   state_t        state_q;
   logic          last_owner_q;
   logic          owner_q;
   logic          we_q;
   logic [2:0]    funct3_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          rvalid0_q;
   logic          rvalid1_q;

   logic          w_idle;
   logic          w_gnt0;
   logic          w_gnt1;
   logic [31:0]   w_ext_data;
   logic          w_ext_err;
   logic          w_range_err;
   logic          w_err;

   // Tie goes to the port that did not win last time
   assign w_idle = (state_q == IDLE) && !reset;
   assign w_gnt0 = w_idle && m0_req && (!m1_req || last_owner_q);
   assign w_gnt1 = w_idle && m1_req && (!m0_req || !last_owner_q);
   assign m0_gnt = w_gnt0;
   assign m1_gnt = w_gnt1;

   load_extend u_load_extend (
      .we_i      (we_q),
      .funct3_i  (funct3_q),
      .addr_lo_i (addr_q[1:0]),
      .word_i    (ram_rdata),
      .data_o    (w_ext_data),
      .err_o     (w_ext_err)
   );

   assign w_range_err = (addr_q[AW-1:2] >= c_DEPTH);
   assign w_err       = w_ext_err || w_range_err;

   // RAM fields always reflect the latched request; only the write strobe
   // is qualified, and reset kills it even mid-ACCESS.
   assign ram_we     = (state_q == ACCESS) && we_q && !w_err && !reset;
   assign ram_funct3 = funct3_q;
   assign ram_addr   = addr_q;
   assign ram_wdata  = wdata_q;

   assign m0_rvalid = rvalid0_q;
   assign m1_rvalid = rvalid1_q;
   assign m0_rdata  = rvalid0_q ? rdata_q : 32'h0;
   assign m1_rdata  = rvalid1_q ? rdata_q : 32'h0;
   assign m0_err    = rvalid0_q & err_q;
   assign m1_err    = rvalid1_q & err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         rdata_q      <= 32'h0;
         err_q        <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  owner_q      <= w_gnt1;
                  last_owner_q <= w_gnt1;
                  we_q         <= w_gnt1 ? m1_we     : m0_we;
                  funct3_q     <= w_gnt1 ? m1_funct3 : m0_funct3;
                  addr_q       <= w_gnt1 ? m1_addr   : m0_addr;
                  wdata_q      <= w_gnt1 ? m1_wdata  : m0_wdata;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q   <= w_err ? 32'h0 : w_ext_data;
               err_q     <= w_err;
               rvalid0_q <= !owner_q;
               rvalid1_q <= owner_q;
               state_q   <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
